prog_divider: RTL and testbench
===============================

Name: prog_divider

Overview:
- Programmable clock-enable divider/timer; next generation of the lab counter that produces the `go` pulse.
- Counts enabled clock cycles and emits a one-cycle `go` pulse every `divideby` counts.
- Adds over the previous generation: parametrised width, shadowed divisor reload at wrap, periodic and one-shot modes, a pause state, and status outputs.
- Drives datapath step enables and display refresh strobes in the lab designs.

Parameters:
- WIDTH, 6, bit width of divisor and count.
- DEFAULT_DIV, 5, divisor value loaded into the active and shadow registers on reset (must be < 2**WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count enable; low pauses counting.
- divideby  input  WIDTH  new divisor value, captured only when load=1.
- load  input  1  one-cycle strobe; captures divideby into the shadow register.
- mode  input  1  0 = periodic, 1 = one-shot.
- start  input  1  one-cycle strobe; arms a one-shot run (ignored when mode=0).
- go  output  1  registered one-cycle terminal pulse.
- countTB  output  WIDTH  current count, for test visibility.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  sticky; set at one-shot completion, cleared by start or load.

Behaviour:
- Reset (async, asserted) values:
  - state=IDLE, countTB=0, go=0, busy=0, done=0.
  - term=DEFAULT_DIV, shadow=DEFAULT_DIV.
- Registers: `term` is the active divisor; `shadow` is the pending divisor.
- load=1: shadow<=divideby. Takes effect in term:
  - at the next wrap, using same-cycle bypass (a load in the wrap cycle is applied immediately);
  - or in the next cycle if state=IDLE.
- States: IDLE, RUN, PAUSE.
- IDLE:
  - countTB held at 0, go=0.
  - mode=0: enable=1 and term!=0 -> RUN.
  - mode=1: start=1 and term!=0 -> RUN; done<=0. enable is not needed to leave IDLE.
- RUN, per posedge with enable=1:
  - countTB==term-1: countTB<=0, go<=1, term<=shadow (or divideby if load is also high).
    - mode=1: additionally -> IDLE, done<=1.
  - otherwise: countTB<=countTB+1, go<=0.
- RUN with enable=0: -> PAUSE; countTB held; go<=0.
- PAUSE: enable=1 -> RUN. The count resumes from the held value with no lost or extra count.
- go period in periodic mode = term enabled cycles. go is high for exactly one cycle per wrap, asserted in the cycle after countTB reads term-1.
- term==1: go on every enabled cycle; countTB stays 0.
- term==0 (reached via wrap reload): at that wrap -> IDLE, no further go.
  - A periodic block restarts when a nonzero divisor is loaded and enable=1.
  - A one-shot block restarts on start.
- start while busy: ignored. mode change while busy: takes effect on the next IDLE exit only (mode sampled at IDLE exit).
- Arithmetic: unsigned, WIDTH bits. Compare against term-1, computed only when term!=0, so there is no underflow.
- Reset mid-run: immediate return to reset values; any pending shadow is discarded.

Decomposition:
- Shared package (divider_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2;
  - mode constants MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1.
- Optional sub-module: prog_divider_ctrl, the state machine plus done/busy logic. The counter and term/shadow registers stay in the top level.

Test Plan:
- Reset, mode=0, enable=1, default term=5 -> countTB sequence 0,1,2,3,4,0…; go pulses exactly every 5 cycles; busy=1 after the first enabled edge.
- Periodic with term=5, drop enable for 4 cycles when countTB=2 -> countTB holds 2 in PAUSE; no go; resumes at 3; next go 3 enabled cycles later.
- load divideby=3 while countTB=1 (term=5) -> current period completes at 5; subsequent go period is 3. A load=7 coincident with the wrap edge -> next period is 7.
- mode=1, load 4 in IDLE, start -> one go pulse after 4 cycles; then IDLE, busy=0, done=1 held; second start clears done and repeats.
- load divideby=1, enable=1 -> go high every cycle, countTB=0. Load 0 -> after the current wrap, IDLE; go stays 0.
- Assert reset asynchronously mid-count (countTB=3, busy=1) -> outputs go to reset values without waiting for a clock edge; after release the period is DEFAULT_DIV.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared encodings for the programmable clock-enable divider and its controller.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/prog_divider_ctrl.sv
// Run-state sequencer for prog_divider: IDLE/RUN/PAUSE, captured run mode, busy and sticky done.
module prog_divider_ctrl
  import divider_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic mode_i,
  input  logic start_i,
  input  logic load_i,
  input  logic term_nz_i,
  input  logic at_term_i,
  input  logic next_term_nz_i,
  output logic idle_o,
  output logic advance_o,
  output logic wrap_o,
  output logic busy_o,
  output logic done_o
);

  state_e state_q;
  logic   mode_q;
  logic   busy_q;
  logic   done_q;

  assign idle_o    = (state_q == ST_IDLE);
  // PAUSE resumes by counting the enabling edge itself, so no enabled cycle is lost.
  assign advance_o = !idle_o && enable_i && term_nz_i;
  assign wrap_o    = advance_o && at_term_i;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch reads the pre-edge values and later writes (done set) win over
  // earlier ones (done clear on load) within the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_PERIODIC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (load_i) done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mode_i == MODE_PERIODIC) begin
            if (enable_i && term_nz_i) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              mode_q  <= MODE_PERIODIC;
            end
          end else if (start_i) begin
            done_q <= 1'b0;
            if (term_nz_i) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              mode_q  <= MODE_ONESHOT;
            end
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (!term_nz_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!enable_i) begin
            state_q <= ST_PAUSE;
          end else if (at_term_i && (mode_q == MODE_ONESHOT || !next_term_nz_i)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (mode_q == MODE_ONESHOT) done_q <= 1'b1;
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/prog_divider.sv
// Programmable clock-enable divider/timer: go pulses once every `term` enabled cycles,
// with a shadowed divisor applied at wrap (or immediately while idle).
module prog_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] divideby,
  input  logic             load,
  input  logic             mode,
  input  logic             start,
  output logic             go,
  output logic [WIDTH-1:0] countTB,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] DEF_TERM = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] term_q;
  logic [WIDTH-1:0] shadow_q;
  logic             go_q;

  logic [WIDTH-1:0] next_term;
  logic             term_nz;
  logic             at_term;
  logic             idle;
  logic             advance;
  logic             wrap;

  // A load in the wrap cycle bypasses the shadow register.
  assign next_term = load ? divideby : shadow_q;
  assign term_nz   = |term_q;
  assign at_term   = term_nz && (count_q == term_q - WIDTH'(1));

  prog_divider_ctrl u_ctrl (
    .clk           (clk),
    .rst           (reset),
    .enable_i      (enable),
    .mode_i        (mode),
    .start_i       (start),
    .load_i        (load),
    .term_nz_i     (term_nz),
    .at_term_i     (at_term),
    .next_term_nz_i(|next_term),
    .idle_o        (idle),
    .advance_o     (advance),
    .wrap_o        (wrap),
    .busy_o        (busy),
    .done_o        (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      term_q   <= DEF_TERM;
      shadow_q <= DEF_TERM;
      go_q     <= 1'b0;
    end else begin
      go_q <= wrap;
      if (load) shadow_q <= divideby;
      if (idle) begin
        count_q <= '0;
        term_q  <= next_term;
      end else if (wrap) begin
        count_q <= '0;
        term_q  <= next_term;
      end else if (advance) begin
        count_q <= count_q + WIDTH'(1);
      end
    end
  end

  assign go      = go_q;
  assign countTB = count_q;

endmodule

// File: tb/tb_prog_divider.sv
// Scoreboard bench for prog_divider: a period-level reference model predicts each cycle's outputs.
module tb_prog_divider;

  localparam int W = 6;
  localparam int DEF = 5;

  typedef struct {
    logic         go;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] divideby;
  logic         load;
  logic         mode;
  logic         start;
  logic         go;
  logic [W-1:0] countTB;
  logic         busy;
  logic         done;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  // Reference model state: a run is either active or not; pausing is simply "no count".
  bit m_running;
  bit m_oneshot;
  bit m_done;
  bit m_go;
  int m_cnt;
  int m_period;
  int m_pend;

  prog_divider #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .divideby(divideby),
    .load    (load),
    .mode    (mode),
    .start   (start),
    .go      (go),
    .countTB (countTB),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_running = 0;
    m_oneshot = 0;
    m_done    = 0;
    m_go      = 0;
    m_cnt     = 0;
    m_period  = DEF;
    m_pend    = DEF;
  endtask

  task automatic model_step(input logic en, input logic ld, input logic [W-1:0] dv,
                            input logic md, input logic st);
    int   pend_next;
    exp_t e;
    pend_next = ld ? int'(dv) : m_pend;
    m_go = 0;
    if (ld) m_done = 0;
    if (!m_running) begin
      m_cnt = 0;
      if (md == 1'b0) begin
        if (en && m_period != 0) begin
          m_running = 1;
          m_oneshot = 0;
        end
      end else if (st) begin
        m_done = 0;
        if (m_period != 0) begin
          m_running = 1;
          m_oneshot = 1;
        end
      end
      m_period = pend_next;
    end else if (m_period == 0) begin
      m_running = 0;
    end else if (en) begin
      if (m_cnt + 1 == m_period) begin
        m_go     = 1;
        m_cnt    = 0;
        m_period = pend_next;
        if (m_oneshot) begin
          m_running = 0;
          m_done    = 1;
        end else if (m_period == 0) begin
          m_running = 0;
        end
      end else begin
        m_cnt++;
      end
    end
    m_pend = pend_next;
    e.go   = m_go;
    e.cnt  = W'(m_cnt);
    e.busy = m_running;
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic en, input logic ld, input logic [W-1:0] dv,
                       input logic md, input logic st);
    enable   = en;
    load     = ld;
    divideby = dv;
    mode     = md;
    start    = st;
    @(posedge clk);
    model_step(en, ld, dv, md, st);
    #1;
  endtask

  // Monitor: compares each predicted cycle on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("go", 32'(go), 32'(e.go));
        check("countTB", 32'(countTB), 32'(e.cnt));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
      end
    end
  end

  initial begin
    logic r_mode;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    load     = 1'b0;
    divideby = '0;
    mode     = 1'b0;
    start    = 1'b0;
    model_reset();
    #3;
    check("reset_count", 32'(countTB), 0);
    check("reset_go", 32'(go), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    #9 reset = 1'b0;

    // Default periodic run.
    for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0, 0);

    // Pause at count 2 for four cycles, then resume.
    for (int i = 0; i < 20 && !(m_running && m_cnt == 2); i++) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0);

    // Shadowed load of 3 mid-period, then load of 7 on a wrap edge.
    for (int i = 0; i < 20 && !(m_running && m_cnt == 1); i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 3, 0, 0);
    for (int i = 0; i < 30 && !(m_period == 3 && m_cnt == 2); i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 7, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 0);

    // Load 0 to retire the periodic run, then one-shot runs of 4.
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 20 && m_running; i++) cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 4, 1, 0);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, 0);

    // Divide-by-one, then load 0.
    cycle(1, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);

    // Asynchronous reset at count 3 while running.
    cycle(1, 1, 5, 0, 0);
    for (int i = 0; i < 20 && !(m_running && m_cnt == 3); i++) cycle(1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    enable = 1'b0;
    load   = 1'b0;
    reset  = 1'b1;
    #1;
    check("async_rst_count", 32'(countTB), 0);
    check("async_rst_go", 32'(go), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_done", 32'(done), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0);

    // Randomised mix of enables, loads, starts and mode changes.
    r_mode = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic         en;
      logic         ld;
      logic         st;
      logic [W-1:0] dv;
      if ($urandom_range(0, 39) == 0) r_mode = ~r_mode;
      en = ($urandom_range(0, 9) < 8);
      ld = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 7) == 0);
      dv = ($urandom_range(0, 9) == 0) ? W'(0) : W'($urandom_range(1, 12));
      cycle(en, ld, dv, r_mode, st);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
